// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control FSM for the 9-bit-instruction core. The instruction is
// latched from mach_code at the end of FETCH and is then walked through
// DECODE / EXEC / MEM / WB. The block drives the ALU-B operand mux selects, the
// PC, register-file and data-memory strobes, counts retired instructions and
// flags data-memory timeouts.
//
// State table
//    state  | meaning
//    IDLE   | after reset, waiting for start
//    FETCH  | ir_load asserted, mach_code captured into irQ on exit
//    DECODE | HALT goes to DONE, everything else to EXEC
//    EXEC   | operand mux selects; BRZ resolves and retires here
//    MEM    | LOAD/STORE request held until mem_ack or timeout
//    WB     | register write, PC += 1, retire
//    DONE   | HALT retired, done held; start restarts
//    ERR    | memory timeout, only rst_n leaves this state
//
// Parameters
//    MEM_TIMEOUT  max MEM cycles waiting for mem_ack before ERR (>= 1)
//    CNT_W        width of the retired-instruction counter
//
// Ports
//    clk, rst_n   clock (rising edge), asynchronous active-low reset
//    start        begin execution, honoured only in IDLE or DONE
//    mach_code    instruction word, valid during FETCH
//    alu_zero     ALU zero flag, used in EXEC of BRZ
//    mem_ack      data-memory completion, used in MEM only
//    ir_load      instruction-register load strobe
//    pc_inc       PC += 1 strobe
//    pc_branch    PC <= branch target strobe
//    isShift      ALU-B select: shift-amount field
//    isAdd        ALU-B select: 1-bit add immediate
//    reg_wr_en    register-file write enable
//    mem_rd       data-memory read request
//    mem_wr       data-memory write request
//    done         HALT retired, held in DONE
//    mem_err      sticky memory-timeout error
//    instr_count  saturating retired-instruction count
// ----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [8:0]       mach_code,
   input  logic             alu_zero,
   input  logic             mem_ack,
   output logic             ir_load,
   output logic             pc_inc,
   output logic             pc_branch,
   output logic             isShift,
   output logic             isAdd,
   output logic             reg_wr_en,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             done,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0] OP_ADDI  = 3'b000;
   localparam logic [2:0] OP_SHIFT = 3'b001;
   localparam logic [2:0] OP_LOAD  = 3'b010;
   localparam logic [2:0] OP_STORE = 3'b011;
   localparam logic [2:0] OP_BRZ   = 3'b100;
   localparam logic [2:0] OP_ALU   = 3'b101;
   localparam logic [2:0] OP_MOV   = 3'b110;
   localparam logic [2:0] OP_HALT  = 3'b111;

   // Wait timer is a down-counter: loaded with MEM_TIMEOUT-1 on MEM entry,
   // terminal count 0 marks the last MEM cycle allowed.
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      DONE   = 3'd6,
      ERR    = 3'd7
   } state_t;

   state_t            state;
   logic [8:0]        irQ;
   logic [WAIT_W-1:0] waitCnt;
   logic [2:0]        opcode;
   logic              retire;
   logic              restart;
   logic              unusedIrBits;

   assign opcode       = irQ[8:6];
   // Operand fields are consumed by the datapath, not by the sequencer.
   assign unusedIrBits = ^irQ[5:0];

   assign restart = start && ((state == IDLE) || (state == DONE));

   always_comb begin
      retire = 1'b0;
      unique case (state)
         DECODE:  retire = (opcode == OP_HALT);
         EXEC:    retire = (opcode == OP_BRZ);
         MEM:     retire = (opcode == OP_STORE) && mem_ack;
         WB:      retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         irQ         <= '0;
         waitCnt     <= '0;
         instr_count <= '0;
      end else begin
         if (restart) begin
            instr_count <= '0;
         end else if (retire && !(&instr_count)) begin
            instr_count <= instr_count + CNT_W'(1);
         end

         unique case (state)
            IDLE: begin
               if (start) state <= FETCH;
            end
            FETCH: begin
               irQ   <= mach_code;
               state <= DECODE;
            end
            DECODE: begin
               state <= (opcode == OP_HALT) ? DONE : EXEC;
            end
            EXEC: begin
               unique case (opcode)
                  OP_LOAD, OP_STORE: begin
                     waitCnt <= WAIT_LOAD;
                     state   <= MEM;
                  end
                  OP_BRZ:  state <= FETCH;
                  default: state <= WB;
               endcase
            end
            MEM: begin
               if (mem_ack) begin
                  state <= (opcode == OP_LOAD) ? WB : FETCH;
               end else if (waitCnt == '0) begin
                  state <= ERR;
               end else begin
                  waitCnt <= waitCnt - WAIT_W'(1);
               end
            end
            WB: begin
               state <= FETCH;
            end
            DONE: begin
               if (start) state <= FETCH;
            end
            ERR: begin
               state <= ERR;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode. State and irQ select the strobe; alu_zero and mem_ack
   // only steer strobes inside the cycle they are defined for, so a
   // reset drops every output in the same cycle.
   always_comb begin
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_branch = 1'b0;
      isShift   = 1'b0;
      isAdd     = 1'b0;
      reg_wr_en = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      done      = 1'b0;
      mem_err   = 1'b0;
      unique case (state)
         FETCH: ir_load = 1'b1;
         EXEC: begin
            isShift = (opcode == OP_SHIFT);
            isAdd   = (opcode == OP_ADDI);
            if (opcode == OP_BRZ) begin
               pc_branch = alu_zero;
               pc_inc    = !alu_zero;
            end
         end
         MEM: begin
            mem_rd = (opcode == OP_LOAD);
            mem_wr = (opcode == OP_STORE);
            pc_inc = (opcode == OP_STORE) && mem_ack;
         end
         WB: begin
            reg_wr_en = 1'b1;
            pc_inc    = 1'b1;
         end
         DONE:    done    = 1'b1;
         ERR:     mem_err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   localparam logic [9:0] O_NONE = 10'b0000000000;
   localparam logic [9:0] O_IRL  = 10'b1000000000;
   localparam logic [9:0] O_PCI  = 10'b0100000000;
   localparam logic [9:0] O_PCB  = 10'b0010000000;
   localparam logic [9:0] O_SH   = 10'b0001000000;
   localparam logic [9:0] O_AD   = 10'b0000100000;
   localparam logic [9:0] O_RW   = 10'b0000010000;
   localparam logic [9:0] O_RD   = 10'b0000001000;
   localparam logic [9:0] O_WR   = 10'b0000000100;
   localparam logic [9:0] O_DN   = 10'b0000000010;
   localparam logic [9:0] O_ER   = 10'b0000000001;

   localparam logic [8:0] I_ADDI  = 9'b000_000001;
   localparam logic [8:0] I_SHIFT = 9'b001_000011;
   localparam logic [8:0] I_LOAD  = 9'b010_000101;
   localparam logic [8:0] I_STORE = 9'b011_000110;
   localparam logic [8:0] I_BRZ   = 9'b100_001000;
   localparam logic [8:0] I_ALU   = 9'b101_010010;
   localparam logic [8:0] I_MOV   = 9'b110_000100;
   localparam logic [8:0] I_HALT  = 9'b111_000000;
   // Driven outside FETCH; decodes as HALT if the DUT ever used live mach_code.
   localparam logic [8:0] JUNK    = 9'b111_111111;

   logic clk;
   logic rst_n, start, alu_zero, mem_ack;
   logic [8:0] mach_code;
   logic ir_load, pc_inc, pc_branch, isShift, isAdd, reg_wr_en;
   logic mem_rd, mem_wr, done, mem_err;
   logic [15:0] instr_count;

   logic rst2, start2, az2, ack2;
   logic [8:0] mc2;
   logic ir_load2, pc_inc2, pc_branch2, isShift2, isAdd2, reg_wr_en2;
   logic mem_rd2, mem_wr2, done2, mem_err2;
   logic [1:0] count2;

   int checks = 0;
   int errors = 0;

   instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mach_code(mach_code),
      .alu_zero(alu_zero), .mem_ack(mem_ack), .ir_load(ir_load), .pc_inc(pc_inc),
      .pc_branch(pc_branch), .isShift(isShift), .isAdd(isAdd), .reg_wr_en(reg_wr_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .done(done), .mem_err(mem_err),
      .instr_count(instr_count)
   );

   instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst2), .start(start2), .mach_code(mc2),
      .alu_zero(az2), .mem_ack(ack2), .ir_load(ir_load2), .pc_inc(pc_inc2),
      .pc_branch(pc_branch2), .isShift(isShift2), .isAdd(isAdd2), .reg_wr_en(reg_wr_en2),
      .mem_rd(mem_rd2), .mem_wr(mem_wr2), .done(done2), .mem_err(mem_err2),
      .instr_count(count2)
   );

   logic [9:0] outs;
   assign outs = {ir_load, pc_inc, pc_branch, isShift, isAdd, reg_wr_en,
                  mem_rd, mem_wr, done, mem_err};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       st;
      logic [8:0] mc;
      logic       az;
      logic       ack;
      logic [9:0] out;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic [8:0] mc, input logic az,
                      input logic ack, input logic [9:0] out, input int cnt);
      vec_t v;
      v.st = st; v.mc = mc; v.az = az; v.ack = ack; v.out = out; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [8:0] mc, input logic az, input logic ack);
      start = st; mach_code = mc; alu_zero = az; mem_ack = ack;
      #1;
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic cyc(input string name, input logic st, input logic [8:0] mc,
                      input logic ack, input logic [9:0] out);
      drive(st, mc, 1'b0, ack);
      chk(name, {22'b0, outs}, {22'b0, out});
      nxt();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mach_code = '0; alu_zero = 1'b0; mem_ack = 1'b0;
      rst2 = 1'b0; start2 = 1'b0; mc2 = '0; az2 = 1'b0; ack2 = 1'b0;

      // Cycle-by-cycle program: {start, mach_code, alu_zero, mem_ack, outputs, count}
      add(0, JUNK, 0, 0, O_NONE, 0);          // IDLE, no start
      add(1, JUNK, 0, 0, O_NONE, 0);          // IDLE, start
      add(0, I_ADDI, 0, 0, O_IRL, 0);         // ADDI: cycles 1..4
      add(0, JUNK, 0, 0, O_NONE, 0);
      add(0, JUNK, 0, 0, O_AD, 0);
      add(0, JUNK, 0, 0, O_RW | O_PCI, 0);
      add(0, I_SHIFT, 0, 0, O_IRL, 1);        // SHIFT
      add(1, JUNK, 0, 0, O_NONE, 1);
      add(0, JUNK, 0, 0, O_SH, 1);
      add(0, JUNK, 0, 0, O_RW | O_PCI, 1);
      add(0, I_BRZ, 0, 0, O_IRL, 2);          // BRZ taken
      add(0, JUNK, 0, 0, O_NONE, 2);
      add(0, JUNK, 1, 0, O_PCB, 2);
      add(0, I_BRZ, 0, 0, O_IRL, 3);          // BRZ not taken
      add(0, JUNK, 1, 0, O_NONE, 3);
      add(0, JUNK, 0, 0, O_PCI, 3);
      add(1, I_LOAD, 0, 1, O_IRL, 4);         // LOAD, 3 waits; start/ack ignored here
      add(0, JUNK, 0, 1, O_NONE, 4);
      add(0, JUNK, 0, 1, O_NONE, 4);
      add(0, JUNK, 0, 0, O_RD, 4);
      add(0, JUNK, 0, 0, O_RD, 4);
      add(0, JUNK, 0, 0, O_RD, 4);
      add(0, JUNK, 0, 1, O_RD, 4);
      add(0, JUNK, 0, 1, O_RW | O_PCI, 4);
      add(0, I_STORE, 0, 0, O_IRL, 5);        // STORE, zero wait
      add(0, JUNK, 0, 0, O_NONE, 5);
      add(0, JUNK, 0, 0, O_NONE, 5);
      add(0, JUNK, 0, 1, O_WR | O_PCI, 5);
      add(0, I_MOV, 0, 0, O_IRL, 6);          // MOV
      add(0, JUNK, 0, 0, O_NONE, 6);
      add(0, JUNK, 0, 0, O_NONE, 6);
      add(0, JUNK, 0, 0, O_RW | O_PCI, 6);
      add(0, I_ALU, 0, 0, O_IRL, 7);          // ALU r-r
      add(0, JUNK, 0, 0, O_NONE, 7);
      add(0, JUNK, 0, 0, O_NONE, 7);
      add(0, JUNK, 0, 0, O_RW | O_PCI, 7);
      add(0, I_HALT, 0, 0, O_IRL, 8);         // HALT
      add(0, JUNK, 0, 0, O_NONE, 8);
      add(0, JUNK, 0, 0, O_DN, 9);
      add(0, JUNK, 0, 1, O_DN, 9);
      add(1, JUNK, 0, 0, O_DN, 9);            // restart
      add(0, I_ADDI, 0, 0, O_IRL, 0);
      add(0, JUNK, 0, 0, O_NONE, 0);
      add(0, JUNK, 0, 0, O_AD, 0);
      add(0, JUNK, 0, 0, O_RW | O_PCI, 0);
      add(0, I_BRZ, 0, 0, O_IRL, 1);
      add(0, JUNK, 0, 0, O_NONE, 1);
      add(0, JUNK, 1, 0, O_PCB, 1);
      add(0, I_STORE, 0, 0, O_IRL, 2);
      add(0, JUNK, 0, 0, O_NONE, 2);
      add(0, JUNK, 0, 0, O_NONE, 2);
      add(0, JUNK, 0, 0, O_WR, 2);
      add(0, JUNK, 0, 1, O_WR | O_PCI, 2);
      add(0, I_HALT, 0, 0, O_IRL, 3);
      add(0, JUNK, 0, 0, O_NONE, 3);
      add(0, JUNK, 0, 0, O_DN, 4);
      add(0, JUNK, 0, 0, O_DN, 4);

      // Reset state
      repeat (2) nxt();
      #1;
      chk("reset outs", {22'b0, outs}, 32'd0);
      chk("reset count", {16'b0, instr_count}, 32'd0);
      nxt();
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].mc, vecs[i].az, vecs[i].ack);
         chk($sformatf("row%0d outs", i), {22'b0, outs}, {22'b0, vecs[i].out});
         chk($sformatf("row%0d count", i), {16'b0, instr_count}, vecs[i].cnt);
         nxt();
      end

      // Memory timeout: STORE never acknowledged
      cyc("to restart", 1, JUNK, 0, O_DN);
      cyc("to fetch", 0, I_STORE, 0, O_IRL);
      cyc("to decode", 0, JUNK, 0, O_NONE);
      cyc("to exec", 0, JUNK, 0, O_NONE);
      for (int k = 1; k <= 15; k++) cyc($sformatf("to mem%0d", k), 0, JUNK, 0, O_WR);
      for (int k = 0; k < 4; k++) cyc($sformatf("err sticky%0d", k), 1, I_ADDI, 1, O_ER);
      chk("err count", {16'b0, instr_count}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("err reset outs", {22'b0, outs}, 32'd0);
      nxt();
      rst_n = 1'b1;
      cyc("post err idle0", 0, JUNK, 0, O_NONE);
      cyc("post err idle1", 0, JUNK, 0, O_NONE);

      // Asynchronous reset in the middle of a LOAD wait
      cyc("ar start", 1, JUNK, 0, O_NONE);
      cyc("ar addi f", 0, I_ADDI, 0, O_IRL);
      cyc("ar addi d", 0, JUNK, 0, O_NONE);
      cyc("ar addi e", 0, JUNK, 0, O_AD);
      cyc("ar addi w", 0, JUNK, 0, O_RW | O_PCI);
      cyc("ar load f", 0, I_LOAD, 0, O_IRL);
      cyc("ar load d", 0, JUNK, 0, O_NONE);
      cyc("ar load e", 0, JUNK, 0, O_NONE);
      drive(0, JUNK, 0, 0);
      chk("ar mem_rd", {22'b0, outs}, {22'b0, O_RD});
      chk("ar count before", {16'b0, instr_count}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ar outs", {22'b0, outs}, 32'd0);
      chk("ar count", {16'b0, instr_count}, 32'd0);
      nxt();
      nxt();
      rst_n = 1'b1;
      cyc("ar idle0", 0, I_ADDI, 1, O_NONE);
      cyc("ar idle1", 0, I_ADDI, 0, O_NONE);
      cyc("ar restart", 1, JUNK, 0, O_NONE);
      cyc("ar fetch", 0, I_ADDI, 0, O_IRL);

      // Counter saturation on a 2-bit counter instance
      rst2 = 1'b1;
      start2 = 1'b1;
      nxt();
      start2 = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         mc2 = I_BRZ;
         nxt();
         mc2 = JUNK;
         nxt();
         nxt();
         #1;
         chk($sformatf("sat brz%0d", n), {30'b0, count2}, (n > 3) ? 32'd3 : n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
